// File: rtl/levmarq_mul_arbiter_if.sv
// Handshake bundle between the levmarq requesters, the shared multiplier and the
// result consumer; the arbiter sits on the slave modport.
interface levmarq_mul_arbiter_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ID_WIDTH   = 2,
    parameter int unsigned DIN_WIDTH  = 7,
    parameter int unsigned DOUT_WIDTH = 7
);
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ*DIN_WIDTH-1:0] req_din0;
    logic [NUM_REQ*DIN_WIDTH-1:0] req_din1;

    logic [DIN_WIDTH-1:0]         mul_din0;
    logic [DIN_WIDTH-1:0]         mul_din1;
    logic [DOUT_WIDTH-1:0]        mul_dout;

    logic                         resp_valid;
    logic                         resp_ready;
    logic [DOUT_WIDTH-1:0]        resp_dout;
    logic [ID_WIDTH-1:0]          resp_id;

    logic                         busy;

    modport slave (
        input  req_valid, req_din0, req_din1, mul_dout, resp_ready,
        output req_ready, mul_din0, mul_din1, resp_valid, resp_dout, resp_id, busy
    );

    modport master (
        output req_valid, req_din0, req_din1, mul_dout, resp_ready,
        input  req_ready, mul_din0, mul_din1, resp_valid, resp_dout, resp_id, busy
    );
endinterface

// File: rtl/levmarq_mul_arbiter.sv
// Round-robin arbiter that time-shares one combinational signed multiplier among
// NUM_REQ requesters through a two-stage issue/result pipeline with backpressure.
module levmarq_mul_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ID_WIDTH   = 2,
    parameter int unsigned DIN_WIDTH  = 7,
    parameter int unsigned DOUT_WIDTH = 7
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    levmarq_mul_arbiter_if.slave  bus
);

    typedef struct packed {
        logic [DIN_WIDTH-1:0] din0;
        logic [DIN_WIDTH-1:0] din1;
        logic [ID_WIDTH-1:0]  id;
    } s1_t;

    typedef struct packed {
        logic [DOUT_WIDTH-1:0] dout;
        logic [ID_WIDTH-1:0]   id;
    } s2_t;

    logic                 s1_valid_q, s1_valid_n;
    s1_t                  s1_q, s1_n;
    logic                 s2_valid_q, s2_valid_n;
    s2_t                  s2_q, s2_n;
    logic [ID_WIDTH-1:0]  rr_ptr_q, rr_ptr_n;
    logic                 busy_q, busy_n;

    logic                 s2_free_c;
    logic                 s1_adv_c;
    logic                 s1_free_c;
    logic                 grant_found_c;
    logic [ID_WIDTH-1:0]  grant_c;
    logic                 accept_c;
    logic [NUM_REQ-1:0]   req_ready_c;
    int unsigned          scan_idx;

    logic [DIN_WIDTH-1:0] din0_arr [NUM_REQ];
    logic [DIN_WIDTH-1:0] din1_arr [NUM_REQ];

    // Unpack the per-requester operand buses.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            din0_arr[i] = bus.req_din0[i*DIN_WIDTH +: DIN_WIDTH];
            din1_arr[i] = bus.req_din1[i*DIN_WIDTH +: DIN_WIDTH];
        end
    end

    assign s2_free_c = !s2_valid_q || bus.resp_ready;
    assign s1_adv_c  = s1_valid_q && s2_free_c;
    assign s1_free_c = !s1_valid_q || s1_adv_c;

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        grant_found_c = 1'b0;
        grant_c       = '0;
        scan_idx      = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            scan_idx = 32'(rr_ptr_q) + k;
            if (scan_idx >= NUM_REQ) begin
                scan_idx = scan_idx - NUM_REQ;
            end
            if (!grant_found_c && bus.req_valid[ID_WIDTH'(scan_idx)]) begin
                grant_found_c = 1'b1;
                grant_c       = ID_WIDTH'(scan_idx);
            end
        end
    end

    // Ready is held low while reset is asserted, even if requesters are valid.
    assign accept_c = ap_rst_n && grant_found_c && s1_free_c;

    always_comb begin
        req_ready_c = '0;
        if (accept_c) begin
            req_ready_c[grant_c] = 1'b1;
        end
    end

    // Next-state for both pipeline stages and the round-robin pointer.
    always_comb begin
        s1_valid_n = s1_valid_q;
        s1_n       = s1_q;
        s2_valid_n = s2_valid_q;
        s2_n       = s2_q;
        rr_ptr_n   = rr_ptr_q;

        if (accept_c) begin
            s1_valid_n = 1'b1;
            s1_n.din0  = din0_arr[grant_c];
            s1_n.din1  = din1_arr[grant_c];
            s1_n.id    = grant_c;
            if (grant_c == ID_WIDTH'(NUM_REQ - 1)) begin
                rr_ptr_n = '0;
            end else begin
                rr_ptr_n = grant_c + ID_WIDTH'(1);
            end
        end else if (s1_adv_c) begin
            // An empty S1 presents zero operands to the multiplier.
            s1_valid_n = 1'b0;
            s1_n       = '0;
        end

        if (s1_adv_c) begin
            s2_valid_n = 1'b1;
            s2_n.dout  = bus.mul_dout;
            s2_n.id    = s1_q.id;
        end else if (bus.resp_ready) begin
            s2_valid_n = 1'b0;
        end

        busy_n = s1_valid_n | s2_valid_n;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_valid_q <= 1'b0;
            s2_q       <= '0;
            rr_ptr_q   <= '0;
            busy_q     <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_n;
            s1_q       <= s1_n;
            s2_valid_q <= s2_valid_n;
            s2_q       <= s2_n;
            rr_ptr_q   <= rr_ptr_n;
            busy_q     <= busy_n;
        end
    end

    assign bus.req_ready  = req_ready_c;
    assign bus.mul_din0   = s1_q.din0;
    assign bus.mul_din1   = s1_q.din1;
    assign bus.resp_valid = s2_valid_q;
    assign bus.resp_dout  = s2_q.dout;
    assign bus.resp_id    = s2_q.id;
    assign bus.busy       = busy_q;

endmodule
